// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the IF/LS memory-port arbiter.
package mem_arbiter_pkg;

  localparam int unsigned PC_WIDTH    = 32;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned LAT_MAX     = 15;

  typedef enum logic [1:0] {
    MA_IDLE  = 2'd0,
    MA_ISSUE = 2'd1,
    MA_WAIT  = 2'd2,
    MA_RESP  = 2'd3
  } ma_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant; last-served updates only on a commit pulse.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_if,
  input  logic   req_ls,
  input  logic   commit,
  input  owner_e commit_owner,
  output logic   gnt_if_c,
  output logic   gnt_ls_c
);

  owner_e last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= OWN_LS;
    end else if (commit) begin
      last_q <= commit_owner;
    end
  end

  // On a tie the requester not served last wins.
  always_comb begin
    gnt_if_c = 1'b0;
    gnt_ls_c = 1'b0;
    if (req_if && req_ls) begin
      if (last_q == OWN_LS) gnt_if_c = 1'b1;
      else                  gnt_ls_c = 1'b1;
    end else begin
      gnt_if_c = req_if;
      gnt_ls_c = req_ls;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store,
// one transaction in flight, with a one-cycle response strobe back to the issuer.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = PC_WIDTH,
  parameter int unsigned DATA_W = INSTR_WIDTH,
  parameter int unsigned LAT    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IfReqValid,
  output logic                IfReqReady,
  input  logic [ADDR_W-1:0]   IfAddr,
  output logic                IfRespValid,
  output logic [DATA_W-1:0]   IfRespData,
  input  logic                LsReqValid,
  output logic                LsReqReady,
  input  logic [ADDR_W-1:0]   LsAddr,
  input  logic                LsWen,
  input  logic [DATA_W-1:0]   LsWdata,
  input  logic [DATA_W/8-1:0] LsWmask,
  output logic                LsRespValid,
  output logic [DATA_W-1:0]   LsRespData,
  output logic                MemEn,
  output logic                MemWen,
  output logic [ADDR_W-1:0]   MemAddr,
  output logic [DATA_W-1:0]   MemWdata,
  output logic [DATA_W/8-1:0] MemWmask,
  input  logic [DATA_W-1:0]   MemRdata
);

  localparam int unsigned MASK_W = DATA_W / 8;

  if (LAT < 1 || LAT > LAT_MAX) begin : g_bad_lat
    $error("mem_arbiter: LAT must be in 1..15");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("mem_arbiter: DATA_W must be a multiple of 8");
  end

  ma_state_e        state_q, state_d;
  owner_e           owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             gnt_if_c, gnt_ls_c;
  logic             idle_c, accept_c;

  rr_arbiter2 u_rr (
    .clk          (clk),
    .rst          (rst),
    .req_if       (IfReqValid),
    .req_ls       (LsReqValid),
    .commit       (state_q == MA_RESP),
    .commit_owner (owner_q),
    .gnt_if_c     (gnt_if_c),
    .gnt_ls_c     (gnt_ls_c)
  );

  // run_q keeps both Ready outputs low while reset is held.
  assign idle_c     = run_q && (state_q == MA_IDLE);
  assign IfReqReady = idle_c && gnt_if_c;
  assign LsReqReady = idle_c && gnt_ls_c;
  assign accept_c   = IfReqReady || LsReqReady;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MA_IDLE:  if (accept_c) state_d = MA_ISSUE;
      MA_ISSUE: state_d = MA_WAIT;
      MA_WAIT:  if (cnt_q == '0) state_d = MA_RESP;
      MA_RESP:  state_d = MA_IDLE;
      default:  state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MA_IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Request capture, memory strobe, latency count and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      MemEn       <= 1'b0;
      MemWen      <= 1'b0;
      MemAddr     <= '0;
      MemWdata    <= '0;
      MemWmask    <= '0;
      IfRespValid <= 1'b0;
      IfRespData  <= '0;
      LsRespValid <= 1'b0;
      LsRespData  <= '0;
    end else begin
      MemEn       <= 1'b0;
      IfRespValid <= 1'b0;
      LsRespValid <= 1'b0;
      case (state_q)
        MA_IDLE: begin
          if (IfReqReady) begin
            owner_q  <= OWN_IF;
            MemEn    <= 1'b1;
            MemWen   <= 1'b0;
            MemAddr  <= IfAddr;
            MemWdata <= '0;
            MemWmask <= MASK_W'(0);
          end else if (LsReqReady) begin
            owner_q  <= OWN_LS;
            MemEn    <= 1'b1;
            MemWen   <= LsWen;
            MemAddr  <= LsAddr;
            MemWdata <= LsWdata;
            MemWmask <= LsWmask;
          end
        end
        MA_ISSUE: cnt_q <= CNT_W'(LAT - 1);
        MA_WAIT: begin
          if (cnt_q == '0) begin
            if (owner_q == OWN_IF) begin
              IfRespValid <= 1'b1;
              IfRespData  <= MemRdata;
            end else begin
              LsRespValid <= 1'b1;
              LsRespData  <= MemWen ? '0 : MemRdata;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LAT=1 instance (dut_a) and LAT=4 instance (dut_b)
// share request inputs; each has its own memory read model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        ls_valid;
  logic [31:0] ls_addr;
  logic        ls_wen;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_wmask;

  logic        if_ready_a, if_rv_a, ls_ready_a, ls_rv_a, mem_en_a, mem_wen_a;
  logic [31:0] if_rd_a, ls_rd_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic [3:0]  mem_wmask_a;
  logic        if_ready_b, if_rv_b, ls_ready_b, ls_rv_b, mem_en_b, mem_wen_b;
  logic [31:0] if_rd_b, ls_rd_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [3:0]  mem_wmask_b;

  int n_chk;
  int n_pass;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h8000_0000: mem_rd = 32'h0000_0413;
      32'h8000_0004: mem_rd = 32'h0010_0093;
      32'h8000_1000: mem_rd = 32'hCAFE_F00D;
      default:       mem_rd = a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  assign mem_rdata_a = mem_rd(mem_addr_a);
  assign mem_rdata_b = mem_rd(mem_addr_b);

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .IfReqValid(if_valid), .IfReqReady(if_ready_a), .IfAddr(if_addr),
    .IfRespValid(if_rv_a), .IfRespData(if_rd_a),
    .LsReqValid(ls_valid), .LsReqReady(ls_ready_a), .LsAddr(ls_addr),
    .LsWen(ls_wen), .LsWdata(ls_wdata), .LsWmask(ls_wmask),
    .LsRespValid(ls_rv_a), .LsRespData(ls_rd_a),
    .MemEn(mem_en_a), .MemWen(mem_wen_a), .MemAddr(mem_addr_a),
    .MemWdata(mem_wdata_a), .MemWmask(mem_wmask_a), .MemRdata(mem_rdata_a)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(4)) dut_b (
    .clk(clk), .rst(rst),
    .IfReqValid(if_valid), .IfReqReady(if_ready_b), .IfAddr(if_addr),
    .IfRespValid(if_rv_b), .IfRespData(if_rd_b),
    .LsReqValid(ls_valid), .LsReqReady(ls_ready_b), .LsAddr(ls_addr),
    .LsWen(ls_wen), .LsWdata(ls_wdata), .LsWmask(ls_wmask),
    .LsRespValid(ls_rv_b), .LsRespData(ls_rd_b),
    .MemEn(mem_en_b), .MemWen(mem_wen_b), .MemAddr(mem_addr_b),
    .MemWdata(mem_wdata_b), .MemWmask(mem_wmask_b), .MemRdata(mem_rdata_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic mid();
    #2;
  endtask

  task automatic idle_inputs();
    if_valid = 1'b0; if_addr  = '0;
    ls_valid = 1'b0; ls_addr  = '0;
    ls_wen   = 1'b0; ls_wdata = '0; ls_wmask = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    cyc(); cyc();
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    idle_inputs();
    cyc();
    if_valid = 1'b1; ls_valid = 1'b1;
    mid();
    check("rst_if_ready", if_ready_a, 0);
    check("rst_ls_ready", ls_ready_a, 0);
    check("rst_mem_en", mem_en_a, 0);
    check("rst_resp", {if_rv_a, ls_rv_a, if_rd_a, ls_rd_a}, 0);
    check("rst_mem_fields", {mem_wen_a, mem_addr_a, mem_wdata_a, mem_wmask_a}, 0);

    // IF-only fetch, LAT=1
    do_reset();
    if_valid = 1'b1; if_addr = 32'h8000_0000;
    mid();
    check("t1_if_ready", if_ready_a, 1);
    check("t1_ls_ready", ls_ready_a, 0);
    check("t1_no_early_en", mem_en_a, 0);
    cyc(); if_valid = 1'b0; mid();
    check("t1_mem_en", mem_en_a, 1);
    check("t1_mem_wen", mem_wen_a, 0);
    check("t1_mem_addr", mem_addr_a, 32'h8000_0000);
    cyc(); mid();
    check("t1_en_one_cycle", mem_en_a, 0);
    check("t1_no_early_resp", if_rv_a, 0);
    cyc(); mid();
    check("t1_if_rv", if_rv_a, 1);
    check("t1_if_rd", if_rd_a, 32'h0000_0413);
    check("t1_ls_rv", ls_rv_a, 0);
    cyc(); mid();
    check("t1_rv_strobe", if_rv_a, 0);

    // Both valid from reset: IF first, then alternation
    do_reset();
    if_valid = 1'b1; if_addr = 32'h8000_0004;
    ls_valid = 1'b1; ls_addr = 32'h8000_1000; ls_wen = 1'b0;
    mid();
    check("t2_tie_if_ready", if_ready_a, 1);
    check("t2_tie_ls_ready", ls_ready_a, 0);
    cyc(); mid();
    check("t2_if_addr", mem_addr_a, 32'h8000_0004);
    cyc(); cyc(); mid();
    check("t2_if_rv", if_rv_a, 1);
    check("t2_if_rd", if_rd_a, 32'h0010_0093);
    check("t2_busy_ls_ready", ls_ready_a, 0);
    cyc(); mid();
    check("t2_ls_ready", ls_ready_a, 1);
    check("t2_if_not_ready", if_ready_a, 0);
    cyc(); mid();
    check("t2_ls_addr", mem_addr_a, 32'h8000_1000);
    check("t2_ls_wen", mem_wen_a, 0);
    cyc(); cyc(); mid();
    check("t2_ls_rv", ls_rv_a, 1);
    check("t2_ls_rd", ls_rd_a, 32'hCAFE_F00D);
    check("t2_if_rv_quiet", if_rv_a, 0);
    cyc(); mid();
    check("t2_alt_if_ready", if_ready_a, 1);
    check("t2_alt_ls_ready", ls_ready_a, 0);
    cyc(); if_valid = 1'b0; ls_valid = 1'b0;
    cyc(); cyc(); mid();
    check("t2_if_rv2", if_rv_a, 1);
    check("t2_ls_rd_hold", ls_rd_a, 32'hCAFE_F00D);
    check("t2_ls_rv_quiet", ls_rv_a, 0);

    // LS store
    cyc();
    ls_valid = 1'b1; ls_addr = 32'h8000_2000; ls_wen = 1'b1;
    ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'hF;
    mid();
    check("t3_ls_ready", ls_ready_a, 1);
    cyc(); ls_valid = 1'b0; mid();
    check("t3_mem_en", mem_en_a, 1);
    check("t3_mem_wen", mem_wen_a, 1);
    check("t3_mem_addr", mem_addr_a, 32'h8000_2000);
    check("t3_mem_wdata", mem_wdata_a, 32'hDEAD_BEEF);
    check("t3_mem_wmask", mem_wmask_a, 4'hF);
    cyc(); mid();
    check("t3_en_one_cycle", mem_en_a, 0);
    cyc(); mid();
    check("t3_ls_rv", ls_rv_a, 1);
    check("t3_ls_rd_zero", ls_rd_a, 0);
    check("t3_if_rd_hold", if_rd_a, 32'h0010_0093);
    cyc(); mid();
    check("t3_rv_strobe", ls_rv_a, 0);

    // LAT=4 fetch with IF request held through the transaction
    do_reset();
    if_valid = 1'b1; if_addr = 32'h8000_0000;
    mid();
    check("t4_if_ready", if_ready_b, 1);
    for (int k = 1; k <= 5; k++) begin
      cyc(); mid();
      check($sformatf("t4_busy_ready_%0d", k), if_ready_b, 0);
      check($sformatf("t4_no_resp_%0d", k), if_rv_b, 0);
      check($sformatf("t4_mem_en_%0d", k), mem_en_b, (k == 1) ? 1 : 0);
    end
    cyc(); mid();
    check("t4_if_rv", if_rv_b, 1);
    check("t4_if_rd", if_rd_b, 32'h0000_0413);
    cyc(); mid();
    check("t4_next_accept", if_ready_b, 1);

    // Reset during the WAIT cycle of an LS load, after IF was last served
    do_reset();
    if_valid = 1'b1; if_addr = 32'h8000_0000;
    cyc(); if_valid = 1'b0;
    cyc(); cyc(); cyc();
    ls_valid = 1'b1; ls_addr = 32'h8000_1000; ls_wen = 1'b0;
    mid();
    check("t5_ls_ready", ls_ready_a, 1);
    cyc(); ls_valid = 1'b0;
    cyc();
    rst = 1'b0; if_valid = 1'b1; ls_valid = 1'b1;
    mid();
    check("t5_rst_mem_en", mem_en_a, 0);
    check("t5_rst_mem_fields", {mem_wen_a, mem_addr_a, mem_wdata_a, mem_wmask_a}, 0);
    check("t5_rst_readys", {if_ready_a, ls_ready_a}, 0);
    check("t5_rst_resp", {if_rv_a, ls_rv_a, if_rd_a, ls_rd_a}, 0);
    cyc(); mid();
    check("t5_rst_held_ls_rv", ls_rv_a, 0);
    cyc();
    rst = 1'b1; if_valid = 1'b0; ls_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mid();
      check($sformatf("t5_no_ls_rv_%0d", k), ls_rv_a, 0);
      check($sformatf("t5_no_mem_en_%0d", k), mem_en_a, 0);
      cyc();
    end
    if_valid = 1'b1; ls_valid = 1'b1;
    mid();
    check("t5_tie_if_ready", if_ready_a, 1);
    check("t5_tie_ls_ready", ls_ready_a, 0);
    cyc(); idle_inputs();
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
